// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller that builds the 16-bit product from
// four partial products of an external combinational 4x4 multiplier.
module mult8x8_seq_ctrl (
   input  logic        clk,
   input  logic        reset_a,
   input  logic        start,
   input  logic [7:0]  dataa,
   input  logic [7:0]  datab,
   output logic [3:0]  mult_a,
   output logic [3:0]  mult_b,
   input  logic [7:0]  mult_prod,
   output logic [15:0] product8x8,
   output logic        done_flag,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CYC0 = 3'd1,
      CYC1 = 3'd2,
      CYC2 = 3'd3,
      CYC3 = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic        load_s;
   logic [7:0]  a_r;
   logic [7:0]  b_r;
   logic [15:0] acc_r;
   logic [15:0] addend_s;
   logic [15:0] sum_s;
   logic [15:0] product_r;
   logic        done_r;
   logic        busy_r;

   // Place a partial product at its nibble weight: lo*lo at 0, cross terms at 4, hi*hi at 8.
   function automatic logic [15:0] align_partial(input state_t st, input logic [7:0] pp);
      logic [15:0] res;
      case (st)
         CYC0:       res = {8'h00, pp};
         CYC1, CYC2: res = {4'h0, pp, 4'h0};
         CYC3:       res = {pp, 8'h00};
         default:    res = 16'h0000;
      endcase
      return res;
   endfunction

   function automatic logic is_busy_state(input state_t st);
      logic res;
      case (st)
         CYC0, CYC1, CYC2, CYC3: res = 1'b1;
         default:                res = 1'b0;
      endcase
      return res;
   endfunction

   // Next-state decode; start is only honoured in IDLE and DONE.
   always_comb begin
      state_s = state_r;
      load_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = CYC0;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         CYC0: state_s = CYC1;
         CYC1: state_s = CYC2;
         CYC2: state_s = CYC3;
         CYC3: state_s = DONE;
         DONE: begin
            if (start) begin
               state_s = CYC0;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Nibble pair presented to the external multiplier in each compute cycle.
   always_comb begin
      mult_a = 4'h0;
      mult_b = 4'h0;
      case (state_r)
         CYC0: begin
            mult_a = a_r[3:0];
            mult_b = b_r[3:0];
         end
         CYC1: begin
            mult_a = a_r[7:4];
            mult_b = b_r[3:0];
         end
         CYC2: begin
            mult_a = a_r[3:0];
            mult_b = b_r[7:4];
         end
         CYC3: begin
            mult_a = a_r[7:4];
            mult_b = b_r[7:4];
         end
         default: begin
            mult_a = 4'h0;
            mult_b = 4'h0;
         end
      endcase
   end

   assign addend_s = align_partial(state_r, mult_prod);
   assign sum_s    = acc_r + addend_s;

   // State register.
   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand latches, written only when a start is accepted.
   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         a_r <= 8'h00;
         b_r <= 8'h00;
      end else if (load_s) begin
         a_r <= dataa;
         b_r <= datab;
      end else begin
         a_r <= a_r;
         b_r <= b_r;
      end
   end

   // Accumulator: cleared on accept, summed in each compute cycle.
   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         acc_r <= 16'h0000;
      end else if (load_s) begin
         acc_r <= 16'h0000;
      end else if (is_busy_state(state_r)) begin
         acc_r <= sum_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   // Result register keeps the last completed product until the next one finishes.
   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         product_r <= 16'h0000;
      end else if (state_r == CYC3) begin
         product_r <= sum_s;
      end else begin
         product_r <= product_r;
      end
   end

   // Status flags registered from the next state so they track the state register exactly.
   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         done_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         done_r <= (state_s == DONE);
         busy_r <= is_busy_state(state_s);
      end
   end

   assign product8x8 = product_r;
   assign done_flag  = done_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Directed bench for mult8x8_seq_ctrl with a behavioural 4x4 multiplier on the side port.
module tb_mult8x8_seq_ctrl;

   logic        clk;
   logic        reset_a;
   logic        start;
   logic [7:0]  dataa;
   logic [7:0]  datab;
   logic [3:0]  mult_a;
   logic [3:0]  mult_b;
   logic [7:0]  mult_prod;
   logic [15:0] product8x8;
   logic        done_flag;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   mult8x8_seq_ctrl dut (
      .clk        (clk),
      .reset_a    (reset_a),
      .start      (start),
      .dataa      (dataa),
      .datab      (datab),
      .mult_a     (mult_a),
      .mult_b     (mult_b),
      .mult_prod  (mult_prod),
      .product8x8 (product8x8),
      .done_flag  (done_flag),
      .busy       (busy)
   );

   assign mult_prod = {4'h0, mult_a} * {4'h0, mult_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_a = 1'b0;
      start   = 1'b0;
      dataa   = 8'h00;
      datab   = 8'h00;
      tick();
      n_tests++;
      if ({product8x8, done_flag, busy, mult_a, mult_b} !== 26'h0) begin
         n_fail++;
         $display("FAIL reset_state: got prod=%h done=%b busy=%b a=%h b=%h, want all zero",
                  product8x8, done_flag, busy, mult_a, mult_b);
      end
      reset_a = 1'b1;
      tick();
      n_tests++;
      if (busy !== 1'b0 || done_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done_flag);
      end
   endtask

   task automatic test_basic();
      logic [3:0] ea [4];
      logic [3:0] eb [4];
      ea[0] = 4'h2; eb[0] = 4'h4;
      ea[1] = 4'h1; eb[1] = 4'h4;
      ea[2] = 4'h2; eb[2] = 4'h3;
      ea[3] = 4'h1; eb[3] = 4'h3;
      dataa = 8'h12; datab = 8'h34; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (mult_a !== ea[i] || mult_b !== eb[i] || busy !== 1'b1 || done_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cyc%0d: got a=%h b=%h busy=%b done=%b, want a=%h b=%h busy=1 done=0",
                     i, mult_a, mult_b, busy, done_flag, ea[i], eb[i]);
         end
         tick();
      end
      n_tests++;
      if (done_flag !== 1'b1 || product8x8 !== 16'h03A8 || busy !== 1'b0 || mult_a !== 4'h0) begin
         n_fail++;
         $display("FAIL basic_done: got done=%b prod=%h busy=%b a=%h, want done=1 prod=03a8 busy=0 a=0",
                  done_flag, product8x8, busy, mult_a);
      end
      tick();
      n_tests++;
      if (done_flag !== 1'b0 || product8x8 !== 16'h03A8) begin
         n_fail++;
         $display("FAIL basic_after: got done=%b prod=%h, want done=0 prod=03a8", done_flag, product8x8);
      end
   endtask

   task automatic test_extremes();
      dataa = 8'hFF; datab = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      n_tests++;
      if (done_flag !== 1'b1 || product8x8 !== 16'hFE01) begin
         n_fail++;
         $display("FAIL max_done: got done=%b prod=%h, want done=1 prod=fe01", done_flag, product8x8);
      end
      tick();
      n_tests++;
      if (done_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL max_pulse: got done=%b one cycle later, want 0", done_flag);
      end
      dataa = 8'h00; datab = 8'hA5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n_tests++;
      if (product8x8 !== 16'hFE01) begin
         n_fail++;
         $display("FAIL zero_hold: got prod=%h mid-run, want fe01", product8x8);
      end
      repeat (3) tick();
      n_tests++;
      if (done_flag !== 1'b1 || product8x8 !== 16'h0000) begin
         n_fail++;
         $display("FAIL zero_done: got done=%b prod=%h, want done=1 prod=0000", done_flag, product8x8);
      end
      tick();
   endtask

   task automatic test_start_ignored();
      dataa = 8'h12; datab = 8'h34; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; dataa = 8'h01; datab = 8'h01;
      tick();
      start = 1'b0;
      n_tests++;
      if (mult_a !== 4'h2 || mult_b !== 4'h3 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL ignore_cyc2: got a=%h b=%h busy=%b, want a=2 b=3 busy=1", mult_a, mult_b, busy);
      end
      tick();
      tick();
      n_tests++;
      if (done_flag !== 1'b1 || product8x8 !== 16'h03A8) begin
         n_fail++;
         $display("FAIL ignore_done: got done=%b prod=%h, want done=1 prod=03a8", done_flag, product8x8);
      end
      tick();
      n_tests++;
      if (busy !== 1'b0 || done_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_idle: got busy=%b done=%b, want 0 0", busy, done_flag);
      end
   endtask

   task automatic test_back_to_back();
      dataa = 8'h10; datab = 8'h10; start = 1'b1;
      tick();
      dataa = 8'h03; datab = 8'h05;
      for (int n = 1; n <= 10; n++) begin
         if (n < 5) begin
            // first run in flight
         end else if (n == 5) begin
            n_tests++;
            if (done_flag !== 1'b1 || product8x8 !== 16'h0100) begin
               n_fail++;
               $display("FAIL b2b_first: got done=%b prod=%h, want done=1 prod=0100", done_flag, product8x8);
            end
         end else if (n < 10) begin
            n_tests++;
            if (done_flag !== 1'b0 || busy !== 1'b1 || product8x8 !== 16'h0100) begin
               n_fail++;
               $display("FAIL b2b_hold%0d: got done=%b busy=%b prod=%h, want done=0 busy=1 prod=0100",
                        n, done_flag, busy, product8x8);
            end
         end else begin
            n_tests++;
            if (done_flag !== 1'b1 || product8x8 !== 16'h000F) begin
               n_fail++;
               $display("FAIL b2b_second: got done=%b prod=%h, want done=1 prod=000f", done_flag, product8x8);
            end
         end
         if (n < 10) tick();
      end
      start = 1'b0;
      tick();
      n_tests++;
      if (done_flag !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: got done=%b busy=%b, want 0 0", done_flag, busy);
      end
   endtask

   task automatic test_reset_mid();
      dataa = 8'h12; datab = 8'h34; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      reset_a = 1'b0;
      #1;
      n_tests++;
      if ({product8x8, done_flag, busy, mult_a, mult_b} !== 26'h0) begin
         n_fail++;
         $display("FAIL midreset_async: got prod=%h done=%b busy=%b a=%h b=%h, want all zero",
                  product8x8, done_flag, busy, mult_a, mult_b);
      end
      tick();
      tick();
      reset_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (done_flag !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_quiet%0d: got done=%b busy=%b, want 0 0", i, done_flag, busy);
         end
      end
      dataa = 8'h07; datab = 8'h09; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      n_tests++;
      if (done_flag !== 1'b1 || product8x8 !== 16'h003F) begin
         n_fail++;
         $display("FAIL midreset_rerun: got done=%b prod=%h, want done=1 prod=003f", done_flag, product8x8);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
